tournament_branch_predictor: RTL and testbench

//  Next-generation conditional-branch direction predictor for the pipelined LC-3b fetch stage.

---
 rtl/tournament_branch_predictor_pkg.sv | 33 +++
 rtl/tournament_branch_predictor_if.sv | 31 +++
 rtl/tournament_branch_predictor_sat_table.sv | 45 ++++
 rtl/tournament_branch_predictor.sv | 110 +++++++++++
 tb/tb_tournament_branch_predictor.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types and counter encodings for the tournament direction predictor.
package tournament_branch_predictor_pkg;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

    function automatic int unsigned ctr_strong_taken(input int unsigned ctr_bits);
        return (32'd1 << ctr_bits) - 32'd1;
    endfunction

    function automatic int unsigned ctr_weak_taken(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 32'd1);
    endfunction

    function automatic int unsigned ctr_weak_not_taken(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_strong_not_taken(input int unsigned ctr_bits);
        return 32'd0 & ctr_bits;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // True when a sweep index addresses an existing entry of a 2**bits table.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned bits);
        return (bits >= 32) ? 1'b1 : ((idx >> bits) == 32'd0);
    endfunction

endpackage

// File: rtl/tournament_branch_predictor_if.sv
// Lookup/resolve bundle between the pipeline (master) and the predictor (slave).
interface tournament_branch_predictor_if #(
    parameter int GHIST_LEN = 6
);
    logic                 ready;
    logic                 predict_valid;
    logic [15:0]          pc;
    logic                 pred_taken;
    logic [GHIST_LEN-1:0] pred_ghr;
    logic [1:0]           pred_meta;
    logic                 update;
    logic [15:0]          update_pc;
    logic                 update_taken;
    logic                 update_mispredict;
    logic [GHIST_LEN-1:0] update_ghr;
    logic [1:0]           update_meta;
    logic [15:0]          branch_count;
    logic [15:0]          mispredict_count;

    modport master (
        input  ready, pred_taken, pred_ghr, pred_meta, branch_count, mispredict_count,
        output predict_valid, pc, update, update_pc, update_taken, update_mispredict,
               update_ghr, update_meta
    );

    modport slave (
        output ready, pred_taken, pred_ghr, pred_meta, branch_count, mispredict_count,
        input  predict_valid, pc, update, update_pc, update_taken, update_mispredict,
               update_ghr, update_meta
    );
endinterface

// File: rtl/tournament_branch_predictor_sat_table.sv
// Table of saturating counters: async read, one sync inc/dec port, one init-write port.
module bp_sat_counter_table
    import tournament_branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 6,
    parameter int CTR_BITS  = 2,
    parameter int INIT_BITS = 6
) (
    input  logic                 clk,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic [CTR_BITS-1:0]  rd_ctr,
    input  logic                 upd_en,
    input  logic [IDX_BITS-1:0]  upd_idx,
    input  logic                 upd_inc,
    input  logic                 init_en,
    input  logic [INIT_BITS-1:0] init_idx
);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_strong_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MIN  = CTR_BITS'(ctr_strong_not_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_weak_taken(CTR_BITS));

    logic [CTR_BITS-1:0] mem [2**IDX_BITS];
    logic [CTR_BITS-1:0] upd_cur;
    logic [CTR_BITS-1:0] upd_nxt;
    logic                init_hit;

    assign rd_ctr   = mem[rd_idx];
    assign upd_cur  = mem[upd_idx];
    assign init_hit = init_en && idx_in_range(32'(init_idx), IDX_BITS);

    always_comb begin
        upd_nxt = upd_cur;
        if (upd_inc && upd_cur != CTR_MAX)
            upd_nxt = upd_cur + CTR_BITS'(1);
        else if (!upd_inc && upd_cur != CTR_MIN)
            upd_nxt = upd_cur - CTR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (init_hit)
            mem[init_idx[IDX_BITS-1:0]] <= CTR_INIT;
        else if (upd_en)
            mem[upd_idx] <= upd_nxt;
    end
endmodule

// File: rtl/tournament_branch_predictor.sv
// Local + gshare tournament direction predictor with speculative global history and
// mispredict repair; tables are swept to their initial values after every reset.
module tournament_branch_predictor
    import tournament_branch_predictor_pkg::*;
#(
    parameter int PC_OFFSET = 1,
    parameter int LHT_BITS  = 3,
    parameter int LHIST_LEN = 4,
    parameter int GHIST_LEN = 6,
    parameter int CTR_BITS  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    tournament_branch_predictor_if.slave bp
);
    localparam int SWEEP_BITS = max3(LHT_BITS, LHIST_LEN, GHIST_LEN);

    bp_state_t              state;
    logic [SWEEP_BITS-1:0]  idx;
    logic [GHIST_LEN-1:0]   spec_ghr;
    logic [15:0]            branch_count;
    logic [15:0]            mispredict_count;
    logic [LHIST_LEN-1:0]   lht [2**LHT_BITS];

    logic                   running, sweeping, do_update, lht_init_hit;
    logic [LHT_BITS-1:0]    li, uli;
    logic [GHIST_LEN-1:0]   pc_g, upc_g;
    logic [LHIST_LEN-1:0]   lh, ulh;
    logic [CTR_BITS-1:0]    lpht_ctr, gpht_ctr, ch_ctr;
    logic                   loc_taken, glb_taken, pred_taken;
    logic                   unused_bits;

    assign running      = (state == BP_RUN);
    assign sweeping     = (state == BP_INIT);
    assign do_update    = running && !rst && bp.update;
    assign lht_init_hit = sweeping && idx_in_range(32'(idx), LHT_BITS);

    assign li    = bp.pc[PC_OFFSET +: LHT_BITS];
    assign uli   = bp.update_pc[PC_OFFSET +: LHT_BITS];
    assign pc_g  = bp.pc[PC_OFFSET +: GHIST_LEN];
    assign upc_g = bp.update_pc[PC_OFFSET +: GHIST_LEN];
    assign lh    = lht[li];
    assign ulh   = lht[uli];

    assign loc_taken  = lpht_ctr[CTR_BITS-1];
    assign glb_taken  = gpht_ctr[CTR_BITS-1];
    assign pred_taken = running && (ch_ctr[CTR_BITS-1] ? glb_taken : loc_taken);

    assign bp.ready            = running;
    assign bp.pred_taken       = pred_taken;
    assign bp.pred_ghr         = spec_ghr;
    assign bp.pred_meta        = running ? {loc_taken, glb_taken} : 2'b00;
    assign bp.branch_count     = branch_count;
    assign bp.mispredict_count = mispredict_count;

    assign unused_bits = ^{bp.pc, bp.update_pc, lpht_ctr, gpht_ctr, ch_ctr};

    bp_sat_counter_table #(.IDX_BITS(LHIST_LEN), .CTR_BITS(CTR_BITS), .INIT_BITS(SWEEP_BITS)) u_lpht (
        .clk(clk), .rd_idx(lh), .rd_ctr(lpht_ctr),
        .upd_en(do_update), .upd_idx(ulh), .upd_inc(bp.update_taken),
        .init_en(sweeping), .init_idx(idx)
    );

    bp_sat_counter_table #(.IDX_BITS(GHIST_LEN), .CTR_BITS(CTR_BITS), .INIT_BITS(SWEEP_BITS)) u_gpht (
        .clk(clk), .rd_idx(pc_g ^ spec_ghr), .rd_ctr(gpht_ctr),
        .upd_en(do_update), .upd_idx(upc_g ^ bp.update_ghr), .upd_inc(bp.update_taken),
        .init_en(sweeping), .init_idx(idx)
    );

    // Chooser moves only when the two components disagreed; toward whichever was right.
    bp_sat_counter_table #(.IDX_BITS(GHIST_LEN), .CTR_BITS(CTR_BITS), .INIT_BITS(SWEEP_BITS)) u_chooser (
        .clk(clk), .rd_idx(pc_g), .rd_ctr(ch_ctr),
        .upd_en(do_update && (bp.update_meta[1] ^ bp.update_meta[0])),
        .upd_idx(upc_g), .upd_inc(bp.update_meta[0] == bp.update_taken),
        .init_en(sweeping), .init_idx(idx)
    );

    always_ff @(posedge clk) begin
        if (lht_init_hit)
            lht[idx[LHT_BITS-1:0]] <= '0;
        else if (do_update)
            lht[uli] <= {ulh[LHIST_LEN-2:0], bp.update_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= BP_INIT;
            idx              <= '0;
            spec_ghr         <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (state == BP_INIT) begin
            idx <= idx + SWEEP_BITS'(1);
            if (idx == '1)
                state <= BP_RUN;
        end else begin
            // A repair wins over a same-cycle lookup: the lookup was on the wrong path.
            if (bp.update && bp.update_mispredict)
                spec_ghr <= {bp.update_ghr[GHIST_LEN-2:0], bp.update_taken};
            else if (bp.predict_valid)
                spec_ghr <= {spec_ghr[GHIST_LEN-2:0], pred_taken};
            if (bp.update) begin
                if (branch_count != 16'hFFFF)
                    branch_count <= branch_count + 16'd1;
                if (bp.update_mispredict && mispredict_count != 16'hFFFF)
                    mispredict_count <= mispredict_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed bench for the tournament predictor: init sweep, training, history, chooser, saturation, reset.
module tb_tournament_branch_predictor;
    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   n;

    tournament_branch_predictor_if #(.GHIST_LEN(6)) bp ();

    tournament_branch_predictor dut (
        .clk(clk),
        .rst(rst),
        .bp(bp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bp.ready && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic lookup(input string tag, input logic [15:0] pc_v, input logic exp_taken,
                          input logic [1:0] exp_meta);
        bp.pc = pc_v;
        #1;
        check({tag, "_taken"}, 32'(bp.pred_taken), 32'(exp_taken));
        check({tag, "_meta"}, 32'(bp.pred_meta), 32'(exp_meta));
    endtask

    task automatic resolve(input logic [15:0] pc_v, input logic taken, input logic mis,
                           input logic [5:0] ghr, input logic [1:0] meta);
        bp.update_pc         = pc_v;
        bp.update_taken      = taken;
        bp.update_mispredict = mis;
        bp.update_ghr        = ghr;
        bp.update_meta       = meta;
        bp.update            = 1'b1;
        @(negedge clk);
        bp.update            = 1'b0;
        bp.update_mispredict = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        bp.predict_valid     = 1'b0;
        bp.pc                = '0;
        bp.update            = 1'b0;
        bp.update_pc         = '0;
        bp.update_taken      = 1'b0;
        bp.update_mispredict = 1'b0;
        bp.update_ghr        = '0;
        bp.update_meta       = '0;

        @(negedge clk);
        check("rst_ready", 32'(bp.ready), 32'd0);
        check("rst_bcnt", 32'(bp.branch_count), 32'd0);
        check("rst_mcnt", 32'(bp.mispredict_count), 32'd0);
        check("rst_ghr", 32'(bp.pred_ghr), 32'd0);

        // Lookups and resolves during the sweep must have no effect.
        rst = 1'b0;
        bp.predict_valid     = 1'b1;
        bp.update            = 1'b1;
        bp.update_mispredict = 1'b1;
        bp.update_taken      = 1'b1;
        bp.update_pc         = 16'h0010;
        lookup("init", 16'h0010, 1'b0, 2'b00);
        wait_ready(n);
        check("init_latency", 32'(n), 32'd64);
        bp.predict_valid     = 1'b0;
        bp.update            = 1'b0;
        bp.update_mispredict = 1'b0;
        check("init_bcnt_held", 32'(bp.branch_count), 32'd0);
        check("init_mcnt_held", 32'(bp.mispredict_count), 32'd0);
        check("init_ghr_held", 32'(bp.pred_ghr), 32'd0);
        lookup("fresh0", 16'h0000, 1'b1, 2'b11);
        lookup("fresh1", 16'h0010, 1'b1, 2'b11);
        lookup("fresh2", 16'hFFFE, 1'b1, 2'b11);
        lookup("fresh3", 16'h1234, 1'b1, 2'b11);

        // Train pc 0x0010 taken twice, then not-taken twice: gpht[0x08] 2->3->3->2->1.
        resolve(16'h0010, 1'b1, 1'b0, 6'd0, 2'b11);
        resolve(16'h0010, 1'b1, 1'b0, 6'd0, 2'b11);
        lookup("trained_t", 16'h0010, 1'b1, 2'b11);
        check("trained_bcnt", 32'(bp.branch_count), 32'd2);
        resolve(16'h0010, 1'b0, 1'b1, 6'd0, 2'b11);
        lookup("nt1", 16'h0010, 1'b1, 2'b11);
        resolve(16'h0010, 1'b0, 1'b1, 6'd0, 2'b11);
        lookup("nt2", 16'h0010, 1'b0, 2'b10);
        check("nt2_bcnt", 32'(bp.branch_count), 32'd4);
        check("nt2_mcnt", 32'(bp.mispredict_count), 32'd2);
        check("nt2_ghr", 32'(bp.pred_ghr), 32'd0);

        // Three taken lookups shift the speculative history 0 -> 1 -> 3 -> 7.
        bp.predict_valid = 1'b1;
        lookup("spec0", 16'h0002, 1'b1, 2'b11);
        check("spec0_ghr", 32'(bp.pred_ghr), 32'd0);
        @(negedge clk);
        check("spec1_ghr", 32'(bp.pred_ghr), 32'd1);
        check("spec1_taken", 32'(bp.pred_taken), 32'd1);
        @(negedge clk);
        check("spec2_ghr", 32'(bp.pred_ghr), 32'd3);
        check("spec2_taken", 32'(bp.pred_taken), 32'd1);
        @(negedge clk);
        bp.predict_valid = 1'b0;
        check("spec3_ghr", 32'(bp.pred_ghr), 32'h07);

        // Repair and lookup in the same cycle: repair wins.
        bp.predict_valid = 1'b1;
        resolve(16'h000C, 1'b0, 1'b1, 6'b000101, 2'b11);
        bp.predict_valid = 1'b0;
        check("repair_ghr", 32'(bp.pred_ghr), 32'h0A);
        check("repair_bcnt", 32'(bp.branch_count), 32'd5);
        check("repair_mcnt", 32'(bp.mispredict_count), 32'd3);

        // Chooser on pc 0x0020 (entry 0x10) with global predicting 0 and local 1.
        resolve(16'h0020, 1'b0, 1'b0, 6'h0A, 2'b11);
        lookup("ch_base", 16'h0020, 1'b0, 2'b10);
        resolve(16'h0020, 1'b1, 1'b0, 6'h3F, 2'b01);
        lookup("ch_inc", 16'h0020, 1'b0, 2'b10);
        resolve(16'h0020, 1'b0, 1'b0, 6'h3F, 2'b01);
        lookup("ch_dec1", 16'h0020, 1'b0, 2'b10);
        resolve(16'h0020, 1'b0, 1'b0, 6'h3F, 2'b11);
        lookup("ch_agree", 16'h0020, 1'b0, 2'b10);
        resolve(16'h0020, 1'b0, 1'b0, 6'h3F, 2'b01);
        lookup("ch_local", 16'h0020, 1'b1, 2'b10);
        check("ch_bcnt", 32'(bp.branch_count), 32'd10);
        check("ch_mcnt", 32'(bp.mispredict_count), 32'd3);

        // Statistics counters saturate at 16'hFFFF.
        bp.update_pc         = 16'h0004;
        bp.update_taken      = 1'b1;
        bp.update_mispredict = 1'b1;
        bp.update_ghr        = '0;
        bp.update_meta       = 2'b11;
        bp.update            = 1'b1;
        repeat (65525) @(negedge clk);
        check("sat_bcnt_edge", 32'(bp.branch_count), 32'hFFFF);
        check("sat_mcnt_edge", 32'(bp.mispredict_count), 32'hFFF8);
        repeat (11) @(negedge clk);
        bp.update            = 1'b0;
        bp.update_mispredict = 1'b0;
        check("sat_bcnt_hold", 32'(bp.branch_count), 32'hFFFF);
        check("sat_mcnt_hold", 32'(bp.mispredict_count), 32'hFFFF);
        check("sat_ghr", 32'(bp.pred_ghr), 32'h01);

        // Reset mid-RUN, then again mid-sweep.
        rst = 1'b1;
        @(negedge clk);
        check("rrst_ready", 32'(bp.ready), 32'd0);
        check("rrst_bcnt", 32'(bp.branch_count), 32'd0);
        check("rrst_mcnt", 32'(bp.mispredict_count), 32'd0);
        check("rrst_ghr", 32'(bp.pred_ghr), 32'd0);
        lookup("rrst", 16'h0020, 1'b0, 2'b00);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_init_ready", 32'(bp.ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        check("reinit_latency", 32'(n), 32'd64);
        lookup("reinit_ch", 16'h0020, 1'b1, 2'b11);
        lookup("reinit_pc10", 16'h0010, 1'b1, 2'b11);
        lookup("reinit_pc0c", 16'h000C, 1'b1, 2'b11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
